// File: rtl/or16_serial_collector.sv
// rtl/or16_serial_collector.sv - bit-serial OR collector, LSB first, valid/ready word output
// Optional out_parity port enabled by defining OR16_PARITY_EN.
module or16_serial_collector #(
    parameter int WIDTH = 16,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
`ifdef OR16_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CW-1:0]    bit_count
);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   shifted;
    logic               accept;

    assign shifted = {a_in | b_in, shreg_q[WIDTH-1:1]};
    assign accept  = in_valid && (state_q == COLLECT);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        if (clear) begin
            // Abort wins over both handshakes; the last delivered word stays visible.
            state_d = COLLECT;
            shreg_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        shreg_d = shifted;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            out_d   = shifted;
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            shreg_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef OR16_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (!clear && accept && (cnt_q == CW'(WIDTH - 1))) begin
            parity_q <= ^shifted;
        end
    end

    assign out_parity = parity_q;
`endif

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign out       = out_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_or16_serial_collector.sv
// tb/tb_or16_serial_collector.sv - directed self-checking bench for or16_serial_collector
module tb_or16_serial_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        a_in;
    logic        b_in;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic [3:0]  bit_count;
`ifdef OR16_PARITY_EN
    logic        out_parity;
`endif

    int nvec = 0;
    int errors = 0;

    or16_serial_collector #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
`ifdef OR16_PARITY_EN
        .out_parity(out_parity),
`endif
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            a_in = a[i];
            b_in = b[i];
            tick();
        end
        in_valid = 1'b0;
        a_in = 1'b0;
        b_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a_in = 1'b0; b_in = 1'b0;
        clear = 1'b0; out_ready = 1'b0;

        // Reset
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_bit_count", 64'(bit_count), 64'd0);
        check("rst_out", 64'(out), 64'h0000);
        rst = 1'b0;

        // Streaming, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            a_in = 16'h00F0 >> i;
            b_in = 16'h0F01 >> i;
            tick();
        end
        check("stream_pre_valid", 64'(out_valid), 64'd0);
        check("stream_pre_count", 64'(bit_count), 64'd15);
        a_in = 1'b0; b_in = 1'b0;
        tick();
        in_valid = 1'b0;
        check("stream_valid", 64'(out_valid), 64'd1);
        check("stream_out", 64'(out), 64'h0FF1);
        check("stream_count_wrap", 64'(bit_count), 64'd0);
`ifdef OR16_PARITY_EN
        check("stream_parity", 64'(out_parity), 64'd1);
`endif
        tick();
        check("stream_valid_one_cycle", 64'(out_valid), 64'd0);
        check("stream_back_collect", 64'(in_ready), 64'd1);

        // Backpressure
        out_ready = 1'b0;
        send_word(16'hA5A5, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a_in = 1'b1;
            b_in = 1'b1;
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out", 64'(out), 64'hA5A5);
            check("bp_count", 64'(bit_count), 64'd0);
        end
        in_valid = 1'b0; a_in = 1'b0; b_in = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_release_count", 64'(bit_count), 64'd0);

        // Gapped input, b all ones
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; a_in = 1'b0; b_in = 1'b1;
            tick();
            check("gap_count_accept", 64'(bit_count), 64'((i + 1) % 16));
            in_valid = 1'b0; b_in = 1'b0;
            tick();
            check("gap_count_idle", 64'(bit_count), 64'((i + 1) % 16));
        end
        check("gap_valid", 64'(out_valid), 64'd1);
        check("gap_out", 64'(out), 64'hFFFF);
`ifdef OR16_PARITY_EN
        check("gap_parity", 64'(out_parity), 64'd0);
`endif
        out_ready = 1'b1;
        tick();
        check("gap_release", 64'(in_ready), 64'd1);

        // clear mid-word
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; a_in = 1'b1; b_in = 1'b0;
            tick();
        end
        check("clr_pre_count", 64'(bit_count), 64'd7);
        clear = 1'b1; in_valid = 1'b1; a_in = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0; a_in = 1'b0;
        check("clr_count", 64'(bit_count), 64'd0);
        check("clr_in_ready", 64'(in_ready), 64'd1);
        check("clr_out_valid", 64'(out_valid), 64'd0);
        check("clr_out_kept", 64'(out), 64'hFFFF);
        send_word(16'h1234, 16'h4321);
        check("clr_word_valid", 64'(out_valid), 64'd1);
        check("clr_word_out", 64'(out), 64'h5335);
`ifdef OR16_PARITY_EN
        check("clr_word_parity", 64'(out_parity), 64'(^16'h5335));
`endif

        // clear in HOLD beats the output handshake; out is kept
        clear = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0; out_ready = 1'b0;
        check("clrhold_valid", 64'(out_valid), 64'd0);
        check("clrhold_ready", 64'(in_ready), 64'd1);
        check("clrhold_out", 64'(out), 64'h5335);

        // rst in HOLD
        send_word(16'h8001, 16'h0100);
        check("rsthold_pre_valid", 64'(out_valid), 64'd1);
        check("rsthold_pre_out", 64'(out), 64'h8101);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsthold_valid", 64'(out_valid), 64'd0);
        check("rsthold_out", 64'(out), 64'h0000);
        check("rsthold_ready", 64'(in_ready), 64'd1);
        check("rsthold_count", 64'(bit_count), 64'd0);
`ifdef OR16_PARITY_EN
        check("rsthold_parity", 64'(out_parity), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errors);
        $finish;
    end

endmodule
